// File: rtl/result_queue.sv
`default_nettype none
// ============================================================================
// Module   : result_queue
// Purpose  : First-word-fall-through result FIFO behind the level-0 write
//            arbiter; tags each result with its search-unit index.
// Revision : 1.0  initial release
// ============================================================================
module result_queue #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_LVL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enableQ,
    input  logic [4:0]               writeQen,
    input  logic [DATA_W-1:0]        dataIn,
    input  logic                     flush,
    output logic                     Qfull,
    output logic                     Qafull,
    output logic                     deqValid,
    input  logic                     deqReady,
    output logic [DATA_W-1:0]        deqData,
    output logic [3:0]               deqSrc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = DATA_W + 4;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL = CW'(AFULL_LVL);

    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          w_wr_req;
    logic          w_wr_acc;
    logic          w_pop;
    logic          w_full;
    logic          w_valid;

    // A write into a full queue is still taken when the head leaves in the
    // same cycle; the freed slot is exactly the one the write pointer targets.
    always_comb begin
        w_valid  = (count_q != '0);
        w_full   = (count_q == C_DEPTH);
        w_wr_req = enableQ & ~writeQen[4];
        w_pop    = w_valid & deqReady;
        w_wr_acc = w_wr_req & (~w_full | w_pop);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (w_wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({w_wr_acc, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (w_wr_req && w_full && !w_pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr_acc) begin
            mem_q[wr_ptr_q] <= {writeQen[3:0], dataIn};
        end
    end

    always_comb begin
        deqValid = w_valid;
        Qfull    = w_full;
        Qafull   = (count_q >= C_AFULL);
        count    = count_q;
        overflow = overflow_q;
        deqSrc   = mem_q[rd_ptr_q][EW-1:DATA_W];
        deqData  = mem_q[rd_ptr_q][DATA_W-1:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_result_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_queue
// Purpose  : Scoreboard bench for result_queue with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_result_queue;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enableQ = 1'b0;
    logic [4:0]        writeQen = 5'h10;
    logic [DATA_W-1:0] dataIn = '0;
    logic              flush = 1'b0;
    logic              Qfull;
    logic              Qafull;
    logic              deqValid;
    logic              deqReady = 1'b0;
    logic [DATA_W-1:0] deqData;
    logic [3:0]        deqSrc;
    logic [4:0]        count;
    logic              overflow;

    logic [67:0] sb [$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_popped = 0;

    result_queue #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_LVL(DEPTH - 2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enableQ (enableQ),
        .writeQen(writeQen),
        .dataIn  (dataIn),
        .flush   (flush),
        .Qfull   (Qfull),
        .Qafull  (Qafull),
        .deqValid(deqValid),
        .deqReady(deqReady),
        .deqData (deqData),
        .deqSrc  (deqSrc),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake that will pop at the coming edge is compared
    // against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !flush && deqValid && deqReady) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", {deqSrc, deqData}, 68'h0);
                n_checks++;
                $display("FAIL pop_with_empty_scoreboard: got valid head, expected none");
            end else begin
                check("pop_order", {deqSrc, deqData}, sb.pop_front());
                n_popped++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [4:0] sel, input logic [63:0] d);
        enableQ  = 1'b1;
        writeQen = sel;
        dataIn   = d;
    endtask

    task automatic idle_write();
        enableQ  = 1'b0;
        writeQen = 5'h10;
    endtask

    task automatic drain(input int max_cycles);
        bit done = 0;
        deqReady = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (!deqValid) begin
                done = 1;
                break;
            end
            tick();
        end
        if (!done && deqValid) begin
            n_checks++;
            $display("FAIL drain_timeout: deqValid still 1 after %0d cycles, expected 0", max_cycles);
        end
        deqReady = 1'b0;
    endtask

    task automatic fill(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            drive_write({1'b0, 4'(i)}, base + 64'(i));
            sb.push_back({4'(i), base + 64'(i)});
            tick();
        end
        idle_write();
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        rst = 1'b0;
        check("reset_count",    68'(count),    68'd0);
        check("reset_deqValid", 68'(deqValid), 68'd0);
        check("reset_Qfull",    68'(Qfull),    68'd0);
        check("reset_Qafull",   68'(Qafull),   68'd0);
        check("reset_overflow", 68'(overflow), 68'd0);

        // Three writes, tagged sources, consumer always ready
        deqReady = 1'b1;
        drive_write(5'h02, 64'hA); sb.push_back({4'd2,  64'hA}); tick();
        check("first_valid_latency", 68'(deqValid), 68'd1);
        drive_write(5'h07, 64'hB); sb.push_back({4'd7,  64'hB}); tick();
        drive_write(5'h0F, 64'hC); sb.push_back({4'd15, 64'hC}); tick();
        idle_write();
        drain(10);
        check("basic_drained", 68'(sb.size()), 68'd0);

        // Fill to full, watch threshold flags
        deqReady = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_write({1'b0, 4'(i)}, 64'h100 + 64'(i));
            sb.push_back({4'(i), 64'h100 + 64'(i)});
            tick();
            check("fill_count",  68'(count),  68'(i + 1));
            check("fill_Qafull", 68'(Qafull), 68'((i + 1) >= 14));
            check("fill_Qfull",  68'(Qfull),  68'((i + 1) == 16));
        end
        drive_write(5'h05, 64'hDEAD); tick(); idle_write();
        check("ovf_count",    68'(count),            68'd16);
        check("ovf_flag",     68'(overflow),         68'd1);
        check("ovf_head",     {deqSrc, deqData},     {4'd0, 64'h100});

        // Full with simultaneous write and pop
        flush = 1'b1; sb.delete(); tick(); flush = 1'b0;
        fill(DEPTH, 64'h200);
        deqReady = 1'b1;
        drive_write(5'h09, 64'h3FF); sb.push_back({4'd9, 64'h3FF});
        tick();
        deqReady = 1'b0; idle_write();
        check("fullpop_count",    68'(count),    68'd16);
        check("fullpop_overflow", 68'(overflow), 68'd0);
        check("fullpop_Qfull",    68'(Qfull),    68'd1);
        drain(40);
        check("fullpop_drained", 68'(sb.size()), 68'd0);
        check("fullpop_count0",  68'(count),     68'd0);

        // No-selection strobe is a no-op
        drive_write(5'h10, 64'hBAD); tick(); idle_write();
        check("nosel_count",    68'(count),    68'd0);
        check("nosel_valid",    68'(deqValid), 68'd0);
        check("nosel_overflow", 68'(overflow), 68'd0);

        // Count 5 with overflow set, flush against a concurrent write
        fill(DEPTH, 64'h400);
        drive_write(5'h03, 64'hBEEF); tick(); idle_write();
        deqReady = 1'b1;
        repeat (11) tick();
        deqReady = 1'b0;
        check("pre_flush_count",    68'(count),    68'd5);
        check("pre_flush_overflow", 68'(overflow), 68'd1);
        flush = 1'b1;
        drive_write(5'h01, 64'h555);
        sb.delete();
        tick();
        flush = 1'b0; idle_write();
        check("flush_count",    68'(count),    68'd0);
        check("flush_valid",    68'(deqValid), 68'd0);
        check("flush_overflow", 68'(overflow), 68'd0);

        // Wrap-around streaming: 40 writes, pops start once 8 are queued
        n_popped = 0;
        for (int i = 0; i < 40; i++) begin
            deqReady = (i >= 8);
            drive_write({1'b0, 4'((i * 7) % 16)}, 64'h1000 + 64'(i * 3));
            sb.push_back({4'((i * 7) % 16), 64'h1000 + 64'(i * 3)});
            tick();
        end
        idle_write();
        drain(40);
        check("wrap_popped", 68'(n_popped), 68'd40);
        check("wrap_sb_empty", 68'(sb.size()), 68'd0);
        check("wrap_overflow", 68'(overflow), 68'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
